pingpong_buffer: RTL

PINGPONG_BUFFER -- requirements
Module: pingpong_buffer

---
 rtl/buffer_pkg.sv | 11 +
 rtl/buffer_bank.sv | 25 ++
 rtl/pingpong_buffer.sv | 98 +++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// Constants shared by the ping-pong buffer and its banks.
package buffer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 16;

    // Bit positions inside the sticky err vector.
    localparam int ERR_WR = 0;
    localparam int ERR_RD = 1;

endpackage

// File: rtl/buffer_bank.sv
// One storage bank: synchronous write, registered read, no reset on storage.
module buffer_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; rdata holds when re is low.
    // The parent only asserts we/re for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong buffer: the writer fills one bank while the reader
// drains the other; wr_done / rd_done hand banks across.
module pingpong_buffer
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_done,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [1:0]            bank_full,
    output logic [1:0]            err
);

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    logic                        wsel, rsel;
    logic                        rd_zero;   // last served read was out of range (or none yet)
    logic                        rd_src;    // bank that served the last read
    logic [1:0][DATA_WIDTH-1:0]  bank_q;
    logic                        wr_in_range, rd_in_range;
    logic                        wr_take, rd_take;
    logic                        wr_mem, rd_mem;

    assign wr_ready    = ~bank_full[wsel];
    assign rd_ready    = bank_full[rsel];
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
    assign wr_take     = wr_en & wr_ready;
    assign rd_take     = rd_en & rd_ready;
    // Storage has no reset, so gate its enables to keep the reset cycle inert.
    assign wr_mem      = wr_take & wr_in_range & rst_n;
    assign rd_mem      = rd_take & rd_in_range & rst_n;

    for (genvar i = 0; i < 2; i++) begin : g_bank
        localparam logic SEL = 1'(i);
        buffer_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (wr_mem && (wsel == SEL)),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_mem && (rsel == SEL)),
            .raddr (rd_addr),
            .rdata (bank_q[i])
        );
    end

    // Bank hand-off, sticky errors and read-response tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            bank_full <= 2'b00;
            err       <= 2'b00;
            rd_valid  <= 1'b0;
            rd_zero   <= 1'b1;
            rd_src    <= 1'b0;
        end else begin
            // wsel bank is empty and rsel bank is full, so both hand-offs
            // in one cycle always touch different flags.
            if (wr_done && wr_ready) begin
                bank_full[wsel] <= 1'b1;
                wsel            <= ~wsel;
            end
            if (rd_done && rd_ready) begin
                bank_full[rsel] <= 1'b0;
                rsel            <= ~rsel;
            end
            if ((wr_en || wr_done) && !wr_ready) err[ERR_WR] <= 1'b1;
            if ((rd_en || rd_done) && !rd_ready) err[ERR_RD] <= 1'b1;
            rd_valid <= rd_take;
            if (rd_take) begin
                rd_zero <= ~rd_in_range;
                rd_src  <= rsel;
            end
        end
    end

    assign rd_data = rd_zero ? '0 : bank_q[rd_src];

endmodule
